xhat_select_mean: RTL and testbench

- Parametrised successor to the single-lane xhat precalc stage in the LCPLC decoder/encoder loop.
- Per slice, a d_flag selects raw xhat or xtilde samples.
- Forwards the selected samples, LANES per beat, and emits the per-slice mean on a second AXI-stream-style output.
- Sits between the xhat reconstruction stage and the next-band predictor.

---
 rtl/lcplc_pkg.sv | 33 +++
 rtl/lane_adder_tree.sv | 25 ++
 rtl/xhat_select_mean.sv | 201 ++++++++++++++++++++
 tb/tb_xhat_select_mean.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcplc_pkg.sv
// Shared sizing helpers and FSM encoding for the LCPLC xhat select/mean stage.
// Build macro XHAT_SEL_ROUND_EN widens the accumulator by one bit for the rounding offset.
package lcplc_pkg;

    typedef enum logic {
        WAIT_FLAG = 1'b0,
        STREAM    = 1'b1
    } sel_state_t;

    function automatic int beats_per_slice(input int block_size_log, input int lanes);
        return (1 << block_size_log) / lanes;
    endfunction

    function automatic int beat_cnt_width(input int block_size_log, input int lanes);
        int w;
        w = block_size_log - $clog2(lanes);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int lane_sum_width(input int data_width, input int lanes);
        return data_width + $clog2(lanes);
    endfunction

    // Sized so a full slice of maximum-valued samples cannot overflow.
    function automatic int acc_width(input int data_width, input int block_size_log);
`ifdef XHAT_SEL_ROUND_EN
        return data_width + block_size_log + 1;
`else
        return data_width + block_size_log;
`endif
    endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// Combinational unsigned sum of LANES packed samples, built as a balanced binary tree.
module lane_adder_tree #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1,
    parameter int SUM_WIDTH  = DATA_WIDTH + $clog2(LANES)
) (
    input  logic [LANES*DATA_WIDTH-1:0] lanes_in,
    output logic [SUM_WIDTH-1:0]        sum_out
);

    // Heap layout: node 0 is the root, leaves occupy LANES-1 .. 2*LANES-2.
    logic [SUM_WIDTH-1:0] node [0:2*LANES-2];

    always_comb begin
        node = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            node[LANES-1+i] = SUM_WIDTH'(lanes_in[i*DATA_WIDTH +: DATA_WIDTH]);
        end
        for (int i = LANES - 2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
        sum_out = node[0];
    end

endmodule

// File: rtl/xhat_select_mean.sv
// Per-slice xhat/xtilde selector: forwards LANES samples per beat and emits the slice mean.
// Build macro XHAT_SEL_ROUND_EN switches the mean from floor to round-half-up.
//
// state     | meaning
// WAIT_FLAG | waiting for the per-slice d_flag; accumulator and beat counter cleared on accept
// STREAM    | consuming xhat/xtilde beats in lockstep until the counter hits the last beat
module xhat_select_mean
    import lcplc_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int BLOCK_SIZE_LOG = 8,
    parameter int LANES          = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES*DATA_WIDTH-1:0] xhat_data,
    input  logic                        xhat_valid,
    output logic                        xhat_ready,
    input  logic                        xhat_last_s,
    input  logic                        xhat_last_b,
    input  logic [LANES*DATA_WIDTH-1:0] xtilde_data,
    input  logic                        xtilde_valid,
    output logic                        xtilde_ready,
    input  logic                        xtilde_last_s,
    input  logic                        d_flag_data,
    input  logic                        d_flag_valid,
    output logic                        d_flag_ready,
    output logic [LANES*DATA_WIDTH-1:0] xhatout_data,
    output logic                        xhatout_valid,
    input  logic                        xhatout_ready,
    output logic                        xhatout_last_s,
    output logic                        xhatout_last_b,
    output logic [DATA_WIDTH-1:0]       xhatoutmean_data,
    output logic                        xhatoutmean_valid,
    input  logic                        xhatoutmean_ready,
    output logic                        error
);

    localparam int BEATS  = beats_per_slice(BLOCK_SIZE_LOG, LANES);
    localparam int CNT_W  = beat_cnt_width(BLOCK_SIZE_LOG, LANES);
    localparam int ACC_W  = acc_width(DATA_WIDTH, BLOCK_SIZE_LOG);
    localparam int SUM_W  = lane_sum_width(DATA_WIDTH, LANES);
    localparam int BEAT_W = LANES * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    sel_state_t         state_q, state_d;
    logic               flag_q, flag_d;
    logic               flag_rdy_q, flag_rdy_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BEAT_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_s_q, out_last_s_d;
    logic               out_last_b_q, out_last_b_d;
    logic [DATA_WIDTH-1:0] mean_q, mean_d;
    logic               mean_valid_q, mean_valid_d;
    logic               error_q, error_d;

    logic [BEAT_W-1:0]  sel_data;
    logic [SUM_W-1:0]   beat_sum;
    logic [ACC_W-1:0]   acc_total;
    logic [ACC_W-1:0]   mean_sum;
    logic [DATA_WIDTH-1:0] mean_calc;
    logic               is_last;
    logic               out_free;
    logic               mean_free;
    logic               in_ready;
    logic               beat_accept;
    logic               flag_hs;
    logic               framing_bad;

    assign sel_data = flag_q ? xhat_data : xtilde_data;

    lane_adder_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .SUM_WIDTH  (SUM_W)
    ) u_lane_sum (
        .lanes_in (sel_data),
        .sum_out  (beat_sum)
    );

    assign acc_total = acc_q + ACC_W'(beat_sum);

`ifdef XHAT_SEL_ROUND_EN
    assign mean_sum = acc_total + (ACC_W'(1) << (BLOCK_SIZE_LOG - 1));
`else
    assign mean_sum = acc_total;
`endif
    assign mean_calc = DATA_WIDTH'(mean_sum >> BLOCK_SIZE_LOG);

    assign is_last   = (cnt_q == LAST_CNT);
    assign out_free  = !out_valid_q || xhatout_ready;
    assign mean_free = !mean_valid_q || xhatoutmean_ready;
    // The closing beat also needs room for its mean, so it stalls behind an undrained mean.
    assign in_ready    = (state_q == STREAM) && out_free && (!is_last || mean_free);
    assign beat_accept = in_ready && xhat_valid && xtilde_valid;
    assign flag_hs     = d_flag_valid && flag_rdy_q;
    assign framing_bad = (xhat_last_s != is_last) || (xtilde_last_s != is_last)
                       || (xhat_last_b && !is_last);

    always_comb begin
        state_d      = state_q;
        flag_d       = flag_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_s_d = out_last_s_q;
        out_last_b_d = out_last_b_q;
        mean_d       = mean_q;
        mean_valid_d = mean_valid_q;
        error_d      = error_q;

        case (state_q)
            WAIT_FLAG: begin
                if (flag_hs) begin
                    flag_d  = d_flag_data;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (beat_accept) begin
                    acc_d = acc_total;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_last) begin
                        state_d = WAIT_FLAG;
                    end
                end
            end
            default: state_d = WAIT_FLAG;
        endcase

        if (beat_accept) begin
            out_data_d   = sel_data;
            out_valid_d  = 1'b1;
            out_last_s_d = xhat_last_s;
            out_last_b_d = xhat_last_b;
        end else if (xhatout_ready) begin
            out_valid_d = 1'b0;
        end

        if (beat_accept && is_last) begin
            mean_d       = mean_calc;
            mean_valid_d = 1'b1;
        end else if (xhatoutmean_ready) begin
            mean_valid_d = 1'b0;
        end

        // The counter stays authoritative; a bad flag only raises the sticky error.
        if (beat_accept && framing_bad) begin
            error_d = 1'b1;
        end

        flag_rdy_d = (state_d == WAIT_FLAG);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WAIT_FLAG;
            flag_q       <= 1'b0;
            flag_rdy_q   <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_s_q <= 1'b0;
            out_last_b_q <= 1'b0;
            mean_q       <= '0;
            mean_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            flag_q       <= flag_d;
            flag_rdy_q   <= flag_rdy_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_s_q <= out_last_s_d;
            out_last_b_q <= out_last_b_d;
            mean_q       <= mean_d;
            mean_valid_q <= mean_valid_d;
            error_q      <= error_d;
        end
    end

    assign xhat_ready        = in_ready;
    assign xtilde_ready      = in_ready;
    assign d_flag_ready      = flag_rdy_q;
    assign xhatout_data      = out_data_q;
    assign xhatout_valid     = out_valid_q;
    assign xhatout_last_s    = out_last_s_q;
    assign xhatout_last_b    = out_last_b_q;
    assign xhatoutmean_data  = mean_q;
    assign xhatoutmean_valid = mean_valid_q;
    assign error             = error_q;

endmodule

// File: tb/tb_xhat_select_mean.sv
// Scoreboard bench for xhat_select_mean with DATA_WIDTH=16, BLOCK_SIZE_LOG=4, LANES=4.
module tb_xhat_select_mean;

    localparam int DW    = 16;
    localparam int BSL   = 4;
    localparam int LN    = 4;
    localparam int BEATS = 4;
    localparam int BW    = DW * LN;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [BW-1:0] xhat_data = '0;
    logic          xhat_valid = 1'b0;
    logic          xhat_ready;
    logic          xhat_last_s = 1'b0;
    logic          xhat_last_b = 1'b0;
    logic [BW-1:0] xtilde_data = '0;
    logic          xtilde_valid = 1'b0;
    logic          xtilde_ready;
    logic          xtilde_last_s = 1'b0;
    logic          d_flag_data = 1'b0;
    logic          d_flag_valid = 1'b0;
    logic          d_flag_ready;
    logic [BW-1:0] xhatout_data;
    logic          xhatout_valid;
    logic          xhatout_ready = 1'b1;
    logic          xhatout_last_s;
    logic          xhatout_last_b;
    logic [DW-1:0] xhatoutmean_data;
    logic          xhatoutmean_valid;
    logic          xhatoutmean_ready = 1'b1;
    logic          error;

    xhat_select_mean #(
        .DATA_WIDTH     (DW),
        .BLOCK_SIZE_LOG (BSL),
        .LANES          (LN)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .xhat_data         (xhat_data),
        .xhat_valid        (xhat_valid),
        .xhat_ready        (xhat_ready),
        .xhat_last_s       (xhat_last_s),
        .xhat_last_b       (xhat_last_b),
        .xtilde_data       (xtilde_data),
        .xtilde_valid      (xtilde_valid),
        .xtilde_ready      (xtilde_ready),
        .xtilde_last_s     (xtilde_last_s),
        .d_flag_data       (d_flag_data),
        .d_flag_valid      (d_flag_valid),
        .d_flag_ready      (d_flag_ready),
        .xhatout_data      (xhatout_data),
        .xhatout_valid     (xhatout_valid),
        .xhatout_ready     (xhatout_ready),
        .xhatout_last_s    (xhatout_last_s),
        .xhatout_last_b    (xhatout_last_b),
        .xhatoutmean_data  (xhatoutmean_data),
        .xhatoutmean_valid (xhatoutmean_valid),
        .xhatoutmean_ready (xhatoutmean_ready),
        .error             (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0] data;
        logic          last_s;
        logic          last_b;
    } beat_t;

    int            checks = 0;
    int            failures = 0;
    beat_t         exp_beat_q[$];
    logic [DW-1:0] exp_mean_q[$];
    logic          drv_last = 1'b0;
    int            slice_cnt = 0;
    bit            tog_done = 1'b0;

    beat_t         mon_e;
    logic [DW-1:0] mon_m;
    logic          prev_ov = 1'b0, prev_or = 1'b0, prev_mv = 1'b0, prev_mr = 1'b0;
    logic [BW-1:0] prev_od = '0;
    logic [DW-1:0] prev_md = '0;

    // Output monitor: pops the scoreboard on each handshake and checks hold-while-stalled.
    always @(negedge clk) begin
        if (!rst) begin
            prev_ov <= 1'b0;
            prev_mv <= 1'b0;
        end else begin
            if (prev_ov && !prev_or) begin
                checks++;
                if (!xhatout_valid || xhatout_data !== prev_od) begin
                    failures++;
                    $display("FAIL beat_hold: valid=%0b data=%h required valid=1 data=%h",
                             xhatout_valid, xhatout_data, prev_od);
                end
            end
            if (prev_mv && !prev_mr) begin
                checks++;
                if (!xhatoutmean_valid || xhatoutmean_data !== prev_md) begin
                    failures++;
                    $display("FAIL mean_hold: valid=%0b mean=%0d required valid=1 mean=%0d",
                             xhatoutmean_valid, xhatoutmean_data, prev_md);
                end
            end
            if (xhatout_valid && xhatout_ready) begin
                checks++;
                if (exp_beat_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_extra: got data=%h with no beat expected", xhatout_data);
                end else begin
                    mon_e = exp_beat_q.pop_front();
                    if ({xhatout_data, xhatout_last_s, xhatout_last_b} !== mon_e) begin
                        failures++;
                        $display("FAIL beat_data: got %h ls=%0b lb=%0b required %h ls=%0b lb=%0b",
                                 xhatout_data, xhatout_last_s, xhatout_last_b,
                                 mon_e.data, mon_e.last_s, mon_e.last_b);
                    end
                end
            end
            if (xhatoutmean_valid && xhatoutmean_ready) begin
                checks++;
                if (exp_mean_q.size() == 0) begin
                    failures++;
                    $display("FAIL mean_extra: got mean=%0d with no mean expected", xhatoutmean_data);
                end else begin
                    mon_m = exp_mean_q.pop_front();
                    if (xhatoutmean_data !== mon_m) begin
                        failures++;
                        $display("FAIL mean_value: got %0d required %0d", xhatoutmean_data, mon_m);
                    end
                end
            end
            prev_ov <= xhatout_valid;
            prev_or <= xhatout_ready;
            prev_od <= xhatout_data;
            prev_mv <= xhatoutmean_valid;
            prev_mr <= xhatoutmean_ready;
            prev_md <= xhatoutmean_data;
        end
    end

    task automatic send_flag(input logic f);
        int n = 0;
        d_flag_data  = f;
        d_flag_valid = 1'b1;
        @(negedge clk);
        while (!d_flag_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL flag_timeout: d_flag_ready=%0b required 1", d_flag_ready);
        end
        @(posedge clk);
        #1;
        d_flag_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [BW-1:0] xh, input logic [BW-1:0] xt,
                             input logic lh, input logic lt, input logic lb, input logic last,
                             input int gap, output int waited);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        xhat_data     = xh;
        xtilde_data   = xt;
        xhat_last_s   = lh;
        xtilde_last_s = lt;
        xhat_last_b   = lb;
        drv_last      = last;
        xhat_valid    = 1'b1;
        xtilde_valid  = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!xhat_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: xhat_ready=%0b required 1", xhat_ready);
        end
        @(posedge clk);
        #1;
        xhat_valid    = 1'b0;
        xtilde_valid  = 1'b0;
        xhat_last_s   = 1'b0;
        xtilde_last_s = 1'b0;
        xhat_last_b   = 1'b0;
        drv_last      = 1'b0;
    endtask

    // mode 0: xhat=100, xtilde=7; mode 1: xhat random, xtilde=ramp; other: both random.
    task automatic send_slice(input logic f, input int mode, input int bad_beat,
                              input int nbeats, input int gapmax, output int max_wait);
        logic [BW-1:0] xh, xt, sel;
        int            sum = 0;
        int            w;
        logic          last;
        slice_cnt++;
        send_flag(f);
        max_wait = 0;
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < LN; l++) begin
                case (mode)
                    0: begin
                        xh[l*DW +: DW] = 16'd100;
                        xt[l*DW +: DW] = 16'd7;
                    end
                    1: begin
                        xh[l*DW +: DW] = 16'($urandom);
                        xt[l*DW +: DW] = 16'(b * LN + l);
                    end
                    default: begin
                        xh[l*DW +: DW] = 16'($urandom);
                        xt[l*DW +: DW] = 16'($urandom);
                    end
                endcase
            end
            sel = f ? xh : xt;
            for (int l = 0; l < LN; l++) sum += int'(sel[l*DW +: DW]);
            last = (b == BEATS - 1);
            exp_beat_q.push_back({sel, last, last});
            if (last) begin
`ifdef XHAT_SEL_ROUND_EN
                exp_mean_q.push_back(16'((sum + (1 << (BSL - 1))) >> BSL));
`else
                exp_mean_q.push_back(16'(sum >> BSL));
`endif
            end
            send_beat(xh, xt, last, last || (b == bad_beat), last, last,
                      (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, w);
            if (w > max_wait) max_wait = w;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (xhatout_valid !== 1'b0 || xhatoutmean_valid !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ov=%0b mv=%0b err=%0b required 0 0 0",
                     xhatout_valid, xhatoutmean_valid, error);
        end
        checks++;
        if (xhat_ready !== 1'b0 || xtilde_ready !== 1'b0 || d_flag_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_readys: xr=%0b tr=%0b fr=%0b required 0 0 0",
                     xhat_ready, xtilde_ready, d_flag_ready);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (d_flag_ready !== 1'b1 || xhat_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait_flag: fr=%0b xr=%0b required 1 0", d_flag_ready, xhat_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_select_xhat();
        int mw;
        send_slice(1'b1, 0, -1, 4, 0, mw);
        checks++;
        if (mw !== 0) begin
            failures++;
            $display("FAIL xhat_no_stall: stall cycles=%0d required 0", mw);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_beat_q.size() != 0 || exp_mean_q.size() != 0) begin
            failures++;
            $display("FAIL drain_xhat: pending beats=%0d means=%0d required 0 0",
                     exp_beat_q.size(), exp_mean_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_select_xtilde();
        int mw;
        send_slice(1'b0, 1, -1, 4, 0, mw);
        repeat (4) @(negedge clk);
        checks++;
        if (exp_beat_q.size() != 0 || exp_mean_q.size() != 0) begin
            failures++;
            $display("FAIL drain_xtilde: pending beats=%0d means=%0d required 0 0",
                     exp_beat_q.size(), exp_mean_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int base, n, w;
        xhatoutmean_ready = 1'b0;
        base = slice_cnt;
        fork
            begin
                send_slice(1'b1, 2, -1, 4, 0, w);
                send_slice(1'b0, 2, -1, 4, 0, w);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!(slice_cnt == base + 2 && drv_last && xhat_valid) && n < 60) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (n >= 60) begin
                    failures++;
                    $display("FAIL b2b_reach_last: last beat of slice 2 not presented, required within 60 cycles");
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        checks++;
                        if (xhat_ready !== 1'b0 || xhatoutmean_valid !== 1'b1
                            || xhatoutmean_data !== exp_mean_q[0]) begin
                            failures++;
                            $display("FAIL b2b_stall: xr=%0b mv=%0b mean=%0d required 0 1 %0d",
                                     xhat_ready, xhatoutmean_valid, xhatoutmean_data, exp_mean_q[0]);
                        end
                        @(negedge clk);
                        n++;
                    end
                end
                while (n < 10) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                xhatoutmean_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        checks++;
        if (exp_beat_q.size() != 0 || exp_mean_q.size() != 0) begin
            failures++;
            $display("FAIL drain_b2b: pending beats=%0d means=%0d required 0 0",
                     exp_beat_q.size(), exp_mean_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ready_toggle();
        int w;
        tog_done = 1'b0;
        fork
            begin
                while (!tog_done) begin
                    @(posedge clk);
                    #1;
                    xhatout_ready = ~xhatout_ready;
                end
            end
            begin
                for (int s = 0; s < 3; s++) begin
                    send_slice(1'($urandom_range(0, 1)), 2, -1, 4, 3, w);
                end
                tog_done = 1'b1;
            end
        join
        xhatout_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (exp_beat_q.size() != 0 || exp_mean_q.size() != 0) begin
            failures++;
            $display("FAIL drain_toggle: pending beats=%0d means=%0d required 0 0",
                     exp_beat_q.size(), exp_mean_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_framing_error();
        int n, w;
        @(negedge clk);
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL err_before: error=%0b required 0", error);
        end
        @(posedge clk);
        #1;
        fork
            send_slice(1'b1, 2, 1, 4, 0, w);
            begin
                n = 0;
                @(negedge clk);
                while (!(xtilde_valid && xtilde_ready && xtilde_last_s && !drv_last) && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (n >= 50) begin
                    failures++;
                    $display("FAIL err_bad_beat: bad xtilde_last_s beat not accepted within 50 cycles");
                end else if (error !== 1'b0) begin
                    failures++;
                    $display("FAIL err_early: error=%0b required 0 before bad beat", error);
                end else begin
                    @(negedge clk);
                    checks++;
                    if (error !== 1'b1) begin
                        failures++;
                        $display("FAIL err_set: error=%0b required 1", error);
                    end
                end
            end
        join
        repeat (4) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: error=%0b required 1", error);
        end
        checks++;
        if (exp_beat_q.size() != 0 || exp_mean_q.size() != 0) begin
            failures++;
            $display("FAIL drain_err: pending beats=%0d means=%0d required 0 0",
                     exp_beat_q.size(), exp_mean_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_slice();
        int w;
        send_slice(1'b1, 1, -1, 2, 0, w);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (xhatout_valid !== 1'b0 || xhatoutmean_valid !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs: ov=%0b mv=%0b err=%0b required 0 0 0",
                     xhatout_valid, xhatoutmean_valid, error);
        end
        checks++;
        if (xhat_ready !== 1'b0 || d_flag_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_readys: xr=%0b fr=%0b required 0 0", xhat_ready, d_flag_ready);
        end
        exp_beat_q.delete();
        exp_mean_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (d_flag_ready !== 1'b1 || xhat_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_wait_flag: fr=%0b xr=%0b required 1 0", d_flag_ready, xhat_ready);
        end
        @(posedge clk);
        #1;
        send_slice(1'b0, 1, -1, 4, 0, w);
        repeat (4) @(negedge clk);
        checks++;
        if (exp_beat_q.size() != 0 || exp_mean_q.size() != 0) begin
            failures++;
            $display("FAIL drain_rst: pending beats=%0d means=%0d required 0 0",
                     exp_beat_q.size(), exp_mean_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_select_xhat();
        test_select_xtilde();
        test_back_to_back();
        test_ready_toggle();
        test_framing_error();
        test_reset_mid_slice();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
